// File: rtl/ps2_note_pkg.sv
// ps2_note_pkg: shared definitions for the PS/2 note-input block.
//   PS2_BREAK / PS2_EXT : set-2 prefix bytes (break and extended).
//   ps2_state_e         : frame receiver FSM states.
//   scan_to_note()      : maps a set-2 scan code to {hit, idx[3:0]}.
package ps2_note_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Top keyboard row Q..I are lanes 0..7, home row A..K are lanes 8..15.
  function automatic logic [4:0] scan_to_note(input logic [7:0] code);
    logic [4:0] r;
    r = 5'd0;
    case (code)
      8'h15: r = {1'b1, 4'd0};
      8'h1D: r = {1'b1, 4'd1};
      8'h24: r = {1'b1, 4'd2};
      8'h2D: r = {1'b1, 4'd3};
      8'h2C: r = {1'b1, 4'd4};
      8'h35: r = {1'b1, 4'd5};
      8'h3C: r = {1'b1, 4'd6};
      8'h43: r = {1'b1, 4'd7};
      8'h1C: r = {1'b1, 4'd8};
      8'h1B: r = {1'b1, 4'd9};
      8'h23: r = {1'b1, 4'd10};
      8'h2B: r = {1'b1, 4'd11};
      8'h34: r = {1'b1, 4'd12};
      8'h33: r = {1'b1, 4'd13};
      8'h3B: r = {1'b1, 4'd14};
      8'h42: r = {1'b1, 4'd15};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_note_input_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 line.
//   clk, reset : system clock, asynchronous active-low reset.
//   raw        : asynchronous line from the keyboard.
//   level      : synchronized, debounced line level (idles at 1).
//   fall       : one-cycle flag, level was 1 last cycle and is 0 now.
// The filtered level only flips after FILTER_LEN consecutive synchronized
// samples disagree with it; any agreeing sample restarts the count.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= level;
      if (sync2 != level) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_note_input.sv
// ps2_note_input: PS/2 keyboard receiver driving a note-lane index.
//   clk         : 100 MHz system clock.
//   reset       : asynchronous active-low reset.
//   ps2_clk     : raw keyboard clock (tristate handled above this block).
//   ps2_data    : raw keyboard data.
//   scan_code   : last valid received byte.
//   code_valid  : one-cycle pulse when scan_code updates.
//   note_idx    : current note lane 0..15.
//   note_valid  : high while the key mapped to note_idx is held.
//   note_strobe : one-cycle pulse on a new note press.
//   frame_err   : one-cycle pulse on start/parity/stop/timeout error.
//   state_dbg   : receiver FSM state for observation.
// Handshake: code_valid and note_strobe are single-cycle qualifiers with no
// back-pressure; consumers must sample them on the cycle they are high.
module ps2_note_input
  import ps2_note_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic [3:0] note_idx,
  output logic       note_valid,
  output logic       note_strobe,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            clk_lvl_unused;
  logic            clk_fall;
  logic            data_lvl;
  logic            data_fall_unused;

  ps2_state_e      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;

  logic            brk;
  logic            ext;
  logic [4:0]      map_res;
  logic            map_hit;
  logic [3:0]      map_idx;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_clk),
    .level (clk_lvl_unused),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_data),
    .level (data_lvl),
    .fall  (data_fall_unused)
  );

  assign state_dbg = state;

  // Frame receiver. Every transition is qualified by a clock fall; the
  // watchdog only runs while a frame is in progress and a fall beats it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (clk_fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_lvl) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {data_lvl, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            par_bit <= data_lvl;
            state   <= STOP;
          end
          STOP: begin
            // Odd parity: the 8 data bits plus parity hold an odd count of 1s.
            if (data_lvl && (^{par_bit, shift_reg})) begin
              scan_code  <= shift_reg;
              code_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign map_res = scan_to_note(scan_code);
  assign map_hit = map_res[4];
  assign map_idx = map_res[3:0];

  // Key tracker, one cycle behind code_valid. Prefixes only arm flags; a
  // key byte consumes and clears both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk         <= 1'b0;
      ext         <= 1'b0;
      note_idx    <= '0;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      if (code_valid) begin
        if (scan_code == PS2_BREAK) begin
          brk <= 1'b1;
        end else if (scan_code == PS2_EXT) begin
          ext <= 1'b1;
        end else begin
          if (!ext && map_hit) begin
            if (!brk) begin
              // A make of the note already held is keyboard auto-repeat.
              if (!(note_valid && (map_idx == note_idx))) begin
                note_idx    <= map_idx;
                note_valid  <= 1'b1;
                note_strobe <= 1'b1;
              end
            end else if (note_valid && (map_idx == note_idx)) begin
              note_valid <= 1'b0;
            end
          end
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_input.sv
module tb_ps2_note_input;
  import ps2_note_pkg::*;

  localparam int HALF = 20;  // half bit period in system clocks

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic [3:0] note_idx;
  logic       note_valid;
  logic       note_strobe;
  logic       frame_err;
  logic [1:0] state_dbg;

  int total;
  int bad;
  int cv_cnt;
  int st_cnt;
  int er_cnt;
  logic got;

  ps2_note_input dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .scan_code   (scan_code),
    .code_valid  (code_valid),
    .note_idx    (note_idx),
    .note_valid  (note_valid),
    .note_strobe (note_strobe),
    .frame_err   (frame_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- pulse monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (code_valid)  cv_cnt = cv_cnt + 1;
      if (note_strobe) st_cnt = st_cnt + 1;
      if (frame_err)   er_cnt = er_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip_par);
    logic par;
    par = ~(^code);
    if (flip_par) par = ~par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       flip_par;
    int         exp_cv;
    int         exp_st;
    int         exp_er;
    logic [7:0] exp_scan;
    logic [3:0] exp_idx;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int c0, s0, e0;
    int err_at;
    total = 0; bad = 0;
    cv_cnt = 0; st_cnt = 0; er_cnt = 0;
    got = 1'b0;

    //            code   flip cv st er scan   idx valid
    vecs[0]  = '{8'h1C, 1'b0, 1, 0, 0, 8'h1C, 4'd8, 1'b1};  // typematic repeat
    vecs[1]  = '{8'hF0, 1'b0, 1, 0, 0, 8'hF0, 4'd8, 1'b1};
    vecs[2]  = '{8'h1C, 1'b0, 1, 0, 0, 8'h1C, 4'd8, 1'b0};  // release held key
    vecs[3]  = '{8'h15, 1'b0, 1, 1, 0, 8'h15, 4'd0, 1'b1};
    vecs[4]  = '{8'h1B, 1'b0, 1, 1, 0, 8'h1B, 4'd9, 1'b1};
    vecs[5]  = '{8'hF0, 1'b0, 1, 0, 0, 8'hF0, 4'd9, 1'b1};
    vecs[6]  = '{8'h15, 1'b0, 1, 0, 0, 8'h15, 4'd9, 1'b1};  // break of non-current key
    vecs[7]  = '{8'h1C, 1'b1, 0, 0, 1, 8'h15, 4'd9, 1'b1};  // parity error
    vecs[8]  = '{8'h24, 1'b0, 1, 1, 0, 8'h24, 4'd2, 1'b1};
    vecs[9]  = '{8'hE0, 1'b0, 1, 0, 0, 8'hE0, 4'd2, 1'b1};
    vecs[10] = '{8'h1C, 1'b0, 1, 0, 0, 8'h1C, 4'd2, 1'b1};  // extended key ignored
    vecs[11] = '{8'h2D, 1'b0, 1, 1, 0, 8'h2D, 4'd3, 1'b1};  // ext flag cleared
    vecs[12] = '{8'h99, 1'b0, 1, 0, 0, 8'h99, 4'd3, 1'b1};  // unmapped key

    // ---------------- reset ----------------
    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(3);
    check("rst_scan", scan_code, 8'h00);
    check("rst_cv", code_valid, 1'b0);
    check("rst_idx", note_idx, 4'd0);
    check("rst_valid", note_valid, 1'b0);
    check("rst_strobe", note_strobe, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_state", state_dbg, IDLE);
    reset = 1'b1;
    wait_cyc(5);

    // ---------------- first frame, pulse timing ----------------
    fork
      send_frame(8'h1C, 1'b0);
      begin
        for (int i = 0; i < 12 * 2 * HALF && !got; i++) begin
          @(negedge clk);
          if (code_valid) got = 1'b1;
        end
        check("seq1_cv_seen", got, 1'b1);
        if (got) begin
          check("seq1_scan", scan_code, 8'h1C);
          check("seq1_valid_not_yet", note_valid, 1'b0);
          @(negedge clk);
          check("seq1_cv_one_cycle", code_valid, 1'b0);
          check("seq1_strobe", note_strobe, 1'b1);
          check("seq1_idx", note_idx, 4'd8);
          check("seq1_valid", note_valid, 1'b1);
          @(negedge clk);
          check("seq1_strobe_one_cycle", note_strobe, 1'b0);
        end
      end
    join
    check("seq1_err", er_cnt, 0);

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 13; v++) begin
      c0 = cv_cnt; s0 = st_cnt; e0 = er_cnt;
      send_frame(vecs[v].code, vecs[v].flip_par);
      check($sformatf("v%0d_cv", v), cv_cnt - c0, vecs[v].exp_cv);
      check($sformatf("v%0d_strobe", v), st_cnt - s0, vecs[v].exp_st);
      check($sformatf("v%0d_err", v), er_cnt - e0, vecs[v].exp_er);
      check($sformatf("v%0d_scan", v), scan_code, vecs[v].exp_scan);
      check($sformatf("v%0d_idx", v), note_idx, vecs[v].exp_idx);
      check($sformatf("v%0d_valid", v), note_valid, vecs[v].exp_valid);
    end

    // ---------------- fall with data high in IDLE ----------------
    e0 = er_cnt; c0 = cv_cnt;
    send_bit(1'b1);
    wait_cyc(2 * HALF);
    check("idle_hi_err", er_cnt - e0, 1);
    check("idle_hi_cv", cv_cnt - c0, 0);
    check("idle_hi_state", state_dbg, IDLE);

    // ---------------- short glitch on ps2_clk ----------------
    e0 = er_cnt; c0 = cv_cnt;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("glitch_err", er_cnt - e0, 0);
    check("glitch_cv", cv_cnt - c0, 0);
    check("glitch_state", state_dbg, IDLE);

    // ---------------- timeout mid-frame ----------------
    e0 = er_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    ps2_data = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b0;  // fall of the 4th data bit
    err_at = -1;
    for (int i = 1; i <= 25000; i++) begin
      @(negedge clk);
      if (i == HALF) ps2_clk = 1'b1;
      if (i == HALF + 20) ps2_data = 1'b1;
      if (frame_err && err_at < 0) err_at = i;
    end
    check("to_seen", (err_at > 0), 1'b1);
    check("to_window", (err_at >= 20000 && err_at <= 20040), 1'b1);
    check("to_err_count", er_cnt - e0, 1);
    check("to_state", state_dbg, IDLE);
    check("to_idx_hold", note_idx, 4'd3);
    c0 = cv_cnt; s0 = st_cnt;
    send_frame(8'h42, 1'b0);
    check("post_to_cv", cv_cnt - c0, 1);
    check("post_to_strobe", st_cnt - s0, 1);
    check("post_to_idx", note_idx, 4'd15);
    check("post_to_valid", note_valid, 1'b1);

    // ---------------- reset mid-frame ----------------
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_cyc(HALF / 2);
    reset = 1'b0;
    #1;
    check("mid_rst_scan", scan_code, 8'h00);
    check("mid_rst_idx", note_idx, 4'd0);
    check("mid_rst_valid", note_valid, 1'b0);
    check("mid_rst_state", state_dbg, IDLE);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(4);
    e0 = er_cnt; c0 = cv_cnt; s0 = st_cnt;
    reset = 1'b1;
    wait_cyc(20);
    send_frame(8'h1C, 1'b0);
    check("after_rst_err", er_cnt - e0, 0);
    check("after_rst_cv", cv_cnt - c0, 1);
    check("after_rst_strobe", st_cnt - s0, 1);
    check("after_rst_scan", scan_code, 8'h1C);
    check("after_rst_idx", note_idx, 4'd8);
    check("after_rst_valid", note_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
